seven_seg_scan_driver: RTL and testbench

//  Time-multiplexed driver for an N-digit common-anode seven-segment display (Basys3: 4 digits).

---
 rtl/seven_seg_pkg.sv | 40 ++++
 rtl/seven_seg_glyph_decoder.sv | 32 +++
 rtl/seven_seg_scan_driver.sv | 175 +++++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan driver.
//   GLYPH_0..GLYPH_F : active-low segment patterns, bit order GFEDCBA
//   SEG_BLANK        : all segments off
//   seven_seg_state_e: per-slot FSM state (ST_BLANK, ST_ON)
//   clog2            : bit width needed to count 0..value-1 (minimum 1)
package seven_seg_pkg;

    localparam logic [6:0] GLYPH_0   = 7'b100_0000;
    localparam logic [6:0] GLYPH_1   = 7'b111_1001;
    localparam logic [6:0] GLYPH_2   = 7'b010_0100;
    localparam logic [6:0] GLYPH_3   = 7'b011_0000;
    localparam logic [6:0] GLYPH_4   = 7'b001_1001;
    localparam logic [6:0] GLYPH_5   = 7'b001_0010;
    localparam logic [6:0] GLYPH_6   = 7'b000_0010;
    localparam logic [6:0] GLYPH_7   = 7'b111_1000;
    localparam logic [6:0] GLYPH_8   = 7'b000_0000;
    localparam logic [6:0] GLYPH_9   = 7'b001_0000;
    localparam logic [6:0] GLYPH_A   = 7'b000_1000;
    localparam logic [6:0] GLYPH_B   = 7'b000_0011;
    localparam logic [6:0] GLYPH_C   = 7'b100_0110;
    localparam logic [6:0] GLYPH_D   = 7'b010_0001;
    localparam logic [6:0] GLYPH_E   = 7'b000_0110;
    localparam logic [6:0] GLYPH_F   = 7'b000_1110;
    localparam logic [6:0] SEG_BLANK = 7'b111_1111;

    typedef enum logic [0:0] {
        ST_BLANK,
        ST_ON
    } seven_seg_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((32'd1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/seven_seg_glyph_decoder.sv
// Combinational hex nibble to active-low seven-segment glyph.
//   nibble_i : 4-bit hex value
//   seg_o    : segments GFEDCBA, active low
module seven_seg_glyph_decoder (
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);
    import seven_seg_pkg::*;

    always_comb begin
        seg_o = SEG_BLANK;
        unique case (nibble_i)
            4'h0: seg_o = GLYPH_0;
            4'h1: seg_o = GLYPH_1;
            4'h2: seg_o = GLYPH_2;
            4'h3: seg_o = GLYPH_3;
            4'h4: seg_o = GLYPH_4;
            4'h5: seg_o = GLYPH_5;
            4'h6: seg_o = GLYPH_6;
            4'h7: seg_o = GLYPH_7;
            4'h8: seg_o = GLYPH_8;
            4'h9: seg_o = GLYPH_9;
            4'hA: seg_o = GLYPH_A;
            4'hB: seg_o = GLYPH_B;
            4'hC: seg_o = GLYPH_C;
            4'hD: seg_o = GLYPH_D;
            4'hE: seg_o = GLYPH_E;
            4'hF: seg_o = GLYPH_F;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// Each digit slot is BLANK_CYCLES of all-anodes-off followed by the lit digit. New
// value/dp/enable data is staged by load_i and copied into the shadow set only at the
// frame wrap, so a frame is never torn. All pins are registered.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits).
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   value_i    : hex nibbles, nibble k drives digit k (digit 0 rightmost)
//   dp_i       : decimal point per digit, 1 = lit
//   digit_en_i : 1 = digit shown, 0 = anode held off
//   load_i     : strobe, stage inputs for the next frame
//   seg_o      : segments GFEDCBA, active low
//   dp_o       : decimal point, active low
//   an_o       : anodes, active low
//   frame_o    : 1-cycle pulse when a new frame (digit 0 slot) begins
module seven_seg_scan_driver #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned REFRESH_HZ   = 1_000,
    parameter int unsigned BLANK_CYCLES = 1_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   digit_en_i,
    input  logic                    load_i,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_o
);
    import seven_seg_pkg::*;

    localparam int unsigned SLOT  = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
    localparam int unsigned CNT_W = clog2(SLOT);
    localparam int unsigned IDX_W = clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT - 1);
    // Last cycle of the blank interval; BLANK_CYCLES must be at least 1.
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    seven_seg_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [NUM_DIGITS-1:0][3:0] stage_val_q, shadow_val_q;
    logic [NUM_DIGITS-1:0]      stage_dp_q, shadow_dp_q;
    logic [NUM_DIGITS-1:0]      stage_en_q, shadow_en_q;
    logic                       pending_q;

    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_q;

    logic                  slot_end;
    logic                  wrap;
    logic [6:0]            glyph;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  digit_on;

    assign slot_end = (state_q == ST_ON) && (cnt_q == CNT_LAST);
    assign wrap     = slot_end && (idx_q == IDX_LAST);

    seven_seg_glyph_decoder u_glyph (
        .nibble_i (shadow_val_q[idx_q]),
        .seg_o    (glyph)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // Walk from the most significant digit down; a zero digit stays dark while every
    // enabled digit above it is also zero. Digit 0 is never suppressed.
    always_comb begin
        logic zero_above;
        lz_blank   = '0;
        zero_above = 1'b1;
        for (int k = int'(NUM_DIGITS) - 1; k > 0; k--) begin
            if (zero_above && (shadow_val_q[k] == 4'h0) && !shadow_dp_q[k]) begin
                lz_blank[k] = 1'b1;
            end
            if (shadow_en_q[k] && (shadow_val_q[k] != 4'h0)) begin
                zero_above = 1'b0;
            end
        end
    end
`else
    assign lz_blank = '0;
`endif

    assign digit_on = shadow_en_q[idx_q] & ~lz_blank[idx_q];

    // Slot timing and digit index.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BLANK: if (cnt_q == BLANK_END) state_d = ST_ON;
            ST_ON:    if (cnt_q == CNT_LAST)  state_d = ST_BLANK;
            default:  state_d = ST_BLANK;
        endcase

        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);

        idx_d = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Pin values for the current state; a disabled or suppressed digit shows nothing,
    // including its decimal point.
    always_comb begin
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        an_d  = '1;
        if ((state_q == ST_ON) && digit_on) begin
            an_d[idx_q] = 1'b0;
            seg_d       = glyph;
            dp_d        = ~shadow_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
            an_q    <= '1;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            frame_q <= wrap;
        end
    end

    // Double buffer. A load on the wrap cycle is staged only; the shadow takes the
    // previously staged set, so the new data waits for the following wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_val_q  <= '0;
            stage_dp_q   <= '0;
            stage_en_q   <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            shadow_en_q  <= '0;
            pending_q    <= 1'b0;
        end else begin
            if (load_i) begin
                stage_val_q <= value_i;
                stage_dp_q  <= dp_i;
                stage_en_q  <= digit_en_i;
            end
            if (wrap && pending_q) begin
                shadow_val_q <= stage_val_q;
                shadow_dp_q  <= stage_dp_q;
                shadow_en_q  <= stage_en_q;
            end
            pending_q <= load_i | (pending_q & ~wrap);
        end
    end

    assign seg_o   = seg_q;
    assign dp_o    = dp_q;
    assign an_o    = an_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with SLOT=25, BLANK_CYCLES=5, 4 digits.
// Positions are counted in clocks after the frame_o cycle; pins lag the FSM by one
// clock, so slot s is dark at pos 25s+1..25s+5 and lit at pos 25s+6..25s+25.
module tb_seven_seg_scan_driver;

    logic        clk;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic        load;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [3:0]  an_o;
    logic        frame_o;

    int checks;
    int errors;
    int pos;

    seven_seg_scan_driver #(
        .NUM_DIGITS   (4),
        .CLK_HZ       (1000),
        .REFRESH_HZ   (10),
        .BLANK_CYCLES (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_i    (value),
        .dp_i       (dp),
        .digit_en_i (en),
        .load_i     (load),
        .seg_o      (seg_o),
        .dp_o       (dp_o),
        .an_o       (an_o),
        .frame_o    (frame_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic goto(input int target);
        while (pos < target) begin
            @(negedge clk);
            pos++;
        end
    endtask

    // Wait (bounded) for frame_o, then restart the position count.
    task automatic sync_frame(input string tag);
        int n;
        n = 0;
        while (frame_o !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, frame_o, 1);
        pos = 0;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] e, input logic [3:0] d);
        value = v;
        en    = e;
        dp    = d;
        load  = 1'b1;
        @(negedge clk);
        pos++;
        load  = 1'b0;
    endtask

    initial begin
        int bad;
        checks = 0;
        errors = 0;
        pos    = 0;
        rst_n  = 1'b0;
        value  = '0;
        dp     = '0;
        en     = '0;
        load   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_seg", seg_o, 7'h7F);
        check("rst_an", an_o, 4'hF);
        check("rst_dp", dp_o, 1'b1);
        check("rst_frame", frame_o, 1'b0);

        // Dark until loaded
        rst_n = 1'b1;
        sync_frame("first_frame");
        goto(10);
        check("dark_an", an_o, 4'hF);

        // 12AF display
        do_load(16'h12AF, 4'hF, 4'h0);
        sync_frame("frame_12af");
        goto(1);
        check("blank_an", an_o, 4'hF);
        check("blank_seg", seg_o, 7'h7F);
        goto(5);
        check("blank_end_an", an_o, 4'hF);
        goto(6);
        check("s0_an", an_o, 4'hE);
        check("s0_seg", seg_o, 7'b000_1110);
        check("s0_dp", dp_o, 1'b1);
        goto(25);
        check("s0_last_an", an_o, 4'hE);
        goto(26);
        check("s1_blank_an", an_o, 4'hF);
        goto(31);
        check("s1_an", an_o, 4'hD);
        check("s1_seg", seg_o, 7'b000_1000);
        goto(81);
        check("s3_an", an_o, 4'h7);
        check("s3_seg", seg_o, 7'b111_1001);
        goto(99);
        check("pre_frame", frame_o, 1'b0);
        goto(100);
        check("frame_period", frame_o, 1'b1);

        // Tear-free: three loads in one frame, last wins at the next wrap
        pos = 0;
        goto(2);
        do_load(16'h1111, 4'hF, 4'h0);
        goto(40);
        do_load(16'h2222, 4'hF, 4'h0);
        goto(56);
        check("tear_s2_an", an_o, 4'hB);
        check("tear_s2_seg", seg_o, 7'b010_0100);
        goto(60);
        do_load(16'h3333, 4'hF, 4'h0);
        goto(81);
        check("tear_s3_seg", seg_o, 7'b111_1001);
        goto(100);
        sync_frame("frame_3333");
        goto(6);
        check("new_s0_seg", seg_o, 7'b011_0000);
        goto(81);
        check("new_s3_seg", seg_o, 7'b011_0000);

        // Load coinciding with the wrap edge
        goto(99);
        do_load(16'h5555, 4'hF, 4'h0);
        check("wrap_load_frame", frame_o, 1'b1);
        pos = 0;
        goto(6);
        check("wrap_load_old", seg_o, 7'b011_0000);
        goto(100);
        sync_frame("frame_5555");
        goto(6);
        check("wrap_load_new", seg_o, 7'b001_0010);

        // Per-digit enable and decimal point on a disabled digit
        goto(10);
        do_load(16'h8888, 4'b0101, 4'b0010);
        goto(100);
        sync_frame("frame_en");
        bad = 0;
        while (pos < 100) begin
            @(negedge clk);
            pos++;
            if (an_o[1] !== 1'b1 || an_o[3] !== 1'b1 || dp_o !== 1'b1) bad++;
            if (pos == 6) check("en_s0_an", an_o, 4'hE);
            if (pos == 56) check("en_s2_an", an_o, 4'hB);
        end
        check("en_disabled_dark", bad, 0);

        // Leading zeros
        do_load(16'h0040, 4'hF, 4'h0);
        sync_frame("frame_lz");
        goto(6);
        check("lz_s0_an", an_o, 4'hE);
        check("lz_s0_seg", seg_o, 7'b100_0000);
        goto(31);
        check("lz_s1_an", an_o, 4'hD);
        check("lz_s1_seg", seg_o, 7'b001_1001);
`ifdef LEADING_ZERO_BLANK_EN
        goto(56);
        check("lz_s2_an", an_o, 4'hF);
        goto(81);
        check("lz_s3_an", an_o, 4'hF);
`else
        goto(56);
        check("lz_s2_an", an_o, 4'hB);
        check("lz_s2_seg", seg_o, 7'b100_0000);
        goto(81);
        check("lz_s3_an", an_o, 4'h7);
        check("lz_s3_seg", seg_o, 7'b100_0000);
`endif

        // Asynchronous reset in the middle of a lit slot
        goto(100);
        sync_frame("frame_pre_rst");
        goto(40);
        check("pre_rst_an", an_o, 4'hD);
        rst_n = 1'b0;
        #1;
        check("mid_rst_seg", seg_o, 7'h7F);
        check("mid_rst_an", an_o, 4'hF);
        check("mid_rst_dp", dp_o, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        sync_frame("frame_post_rst");
        goto(6);
        check("post_rst_s0_an", an_o, 4'hF);
        goto(31);
        check("post_rst_s1_an", an_o, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
